multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle RV32I control FSM. It succeeds the single-cycle combinational decoder and drives a shared-memory datapath with IR/OldPC/A/ALUOut/Data registers.
- Covers the full base integer set: loads, stores, ALU-reg, ALU-imm, all six branches, JAL, JALR, LUI and AUIPC.
- Adds a memory ready handshake and an illegal-instruction trap.

Parameters:
- MEM_WAIT, 1, 1: FETCH/MEM_READ/MEM_WRITE hold until mem_ready. 0: mem_ready ignored, treated as 1.
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters sticky TRAP. 0: an unknown opcode returns to FETCH as a NOP.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  PC <= result
- adr_src  out  1  0 = PC, 1 = result
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR <= rdata, OldPC <= PC
- reg_write  out  1  rd <= result
- alu_src_a  out  2  00 PC, 01 OLDPC, 10 REG, 11 ZERO
- alu_src_b  out  2  00 REG, 01 IMM, 10 FOUR
- result_src  out  2  00 ALUOUT, 01 DATA, 10 ALU_RESULT
- imm_src  out  3  I, S, B, U, J
- alu_control  out  4  ALU operation
- illegal_instr  out  1  high while in TRAP

Behaviour:
- Reset: while rst is high, every output is 0. On the next edge the state becomes FETCH.
  - rst high in any state aborts the instruction: no pc_write, reg_write or mem_write in that cycle.
- Output style: Moore from state, except these terms are gated by mem_ready:
  - pc_write and ir_write in FETCH
  - pc_write in BRANCH (gated by taken, not mem_ready)
- FETCH: adr_src=0, mem_read=1, a=PC, b=FOUR, ADD, result_src=ALU_RESULT.
  - When mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay in FETCH with no writes.
- DECODE: a=OLDPC, b=IMM, imm_src=B, ADD (branch target into ALUOut). Next state by opcode:
  - LOAD/STORE -> MEM_ADR
  - R -> EXEC_R
  - OP-IMM -> EXEC_I
  - BRANCH -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI -> EXEC_LUI
  - AUIPC -> EXEC_AUIPC
  - other -> TRAP (TRAP_ON_ILLEGAL=1) or FETCH (0)
- MEM_ADR: a=REG, b=IMM, ADD. imm_src=I for LOAD, S for STORE. Goes to MEM_READ or MEM_WRITE.
- MEM_READ: adr_src=1, result_src=ALUOUT, mem_read=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: result_src=DATA, reg_write=1, then FETCH.
- MEM_WRITE: adr_src=1, result_src=ALUOUT, mem_write=1. Holds until mem_ready, then FETCH.
  - mem_write stays high for every wait cycle.
- EXEC_R: a=REG, b=REG, decoded op. EXEC_I: a=REG, b=IMM, imm_src=I, decoded op. Both go to ALU_WB.
- EXEC_LUI: a=ZERO, b=IMM, U, ADD. EXEC_AUIPC: a=OLDPC, b=IMM, U, ADD. Both go to ALU_WB.
- ALU_WB: result_src=ALUOUT, reg_write=1, then FETCH.
- BRANCH: a=REG, b=REG, result_src=ALUOUT, then FETCH. Operation and taken condition by funct3:
  - BEQ/BNE use SUB; taken = alu_zero / !alu_zero.
  - BLT/BGE use SLT; BLTU/BGEU use SLTU; taken = !alu_zero for BLT/BLTU, alu_zero for BGE/BGEU.
  - pc_write = taken.
  - funct3 010/011 is illegal and goes to TRAP or FETCH per TRAP_ON_ILLEGAL.
- JAL: imm_src=J, a=OLDPC, b=IMM, ADD (target into ALUOut), no pc_write, then JAL_JUMP.
- JAL_JUMP: result_src=ALUOUT, pc_write=1, then LINK.
- JALR: a=REG, b=IMM, I, ADD, result_src=ALU_RESULT, pc_write=1, then LINK.
  - rs1 was latched at DECODE, so rd==rs1 is safe. The datapath clears target bit 0.
- LINK: a=OLDPC, b=FOUR, ADD, result_src=ALU_RESULT, reg_write=1, then FETCH.
- ALU decode, EXEC_R/EXEC_I:
  - funct3 000: SUB only if opcode[5] & funct7[5], else ADD.
  - funct3 101: SRA if funct7[5], else SRL. Other funct7 bits are ignored.
  - Remaining funct3 values map one-to-one to SLL, SLT, SLTU, XOR, OR, AND.
- TRAP: illegal_instr=1, all enables 0. Exits only on rst.
- Latency with zero memory wait: R/I/LUI/AUIPC 4, LOAD 5, STORE 4, BRANCH 3, JAL 5, JALR 4. Each memory wait cycle adds 1.

Decomposition:
- pkg gains:
  - opcode constants for BRANCH, JAL, JALR, LUI and AUIPC
  - branch funct3 constants
  - enums for the FSM state, alu_src_a, alu_src_b, result_src and imm_src (3-bit)
  - existing ALU_* codes, reused
- One combinational sub-module, alu_decoder: inputs alu_op, opcode[5], funct3, funct7[5]; output alu_control.

Test Plan:
- ADD x3,x1,x2 with mem_ready tied high -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 4; alu_control=ALU_ADD.
- LW with MEM_WAIT=1 and mem_ready low for 2 cycles in FETCH and 3 in MEM_READ -> FETCH holds 3 cycles with ir_write=0 until ready; total 10 cycles; reg_write with result_src=DATA.
- BNE with alu_zero=0 -> pc_write=1 in BRANCH. Repeat with alu_zero=1 -> pc_write=0. BGEU uses SLTU and is taken when alu_zero=1.
- JALR x1,0(x1) -> pc_write in JALR with result_src=ALU_RESULT; LINK next cycle with reg_write=1, a=OLDPC, b=FOUR.
- Opcode 7'h7F -> TRAP, illegal_instr=1 stays high 20 cycles with all enables 0. rst high then FETCH. With TRAP_ON_ILLEGAL=0 -> FETCH right after DECODE.
- rst asserted during MEM_WRITE wait -> mem_write=0 that cycle, FETCH on the next edge, no reg_write.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// ------------------------------------------------------------------
// multicycle_control_pkg: shared encodings for the RV32I control FSM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package multicycle_control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC, S_ALU_WB,
    S_BRANCH, S_JAL, S_JAL_JUMP, S_JALR, S_LINK, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    SRC_A_PC = 2'b00, SRC_A_OLDPC = 2'b01, SRC_A_REG = 2'b10, SRC_A_ZERO = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_REG = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU_RESULT = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
  } imm_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00, ALUOP_BRANCH = 2'b01, ALUOP_FUNCT = 2'b10
  } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
// ------------------------------------------------------------------
// multicycle_control_alu_decoder: maps alu_op/funct fields to ALU op
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic       op_bit5,
  input  logic [2:0] funct3,
  input  logic       funct7_bit5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: begin
        // BLT/BGE compare signed, BLTU/BGEU unsigned, BEQ/BNE subtract
        case (funct3[2:1])
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_SUB;
        endcase
      end
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_bit5 & funct7_bit5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_bit5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ------------------------------------------------------------------
// multicycle_control: RV32I multicycle control FSM, shared-memory datapath
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_WAIT        = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal_instr
);

  state_t  r_state;
  alu_op_t w_alu_op;
  logic    w_ready;
  logic    w_taken;
  logic    w_branch_ok;
  logic    w_unused;

  assign w_ready     = MEM_WAIT ? mem_ready : 1'b1;
  assign w_branch_ok = (funct3[2:1] != 2'b01);
  assign w_unused    = ^{funct7[6], funct7[4:0]};

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      F3_BEQ:           w_taken = alu_zero;
      F3_BNE:           w_taken = !alu_zero;
      F3_BLT, F3_BLTU:  w_taken = !alu_zero;
      F3_BGE, F3_BGEU:  w_taken = alu_zero;
      default:          w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:      if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: r_state <= S_MEM_ADR;
            OP_R:              r_state <= S_EXEC_R;
            OP_IMM:            r_state <= S_EXEC_I;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_LUI:            r_state <= S_EXEC_LUI;
            OP_AUIPC:          r_state <= S_EXEC_AUIPC;
            default:           r_state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          endcase
        end
        // opcode bit 5 separates STORE from LOAD
        S_MEM_ADR:    r_state <= opcode[5] ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:   if (w_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE:  if (w_ready) r_state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC: r_state <= S_ALU_WB;
        S_BRANCH: begin
          if (w_branch_ok || !TRAP_ON_ILLEGAL) r_state <= S_FETCH;
          else                                 r_state <= S_TRAP;
        end
        S_JAL:        r_state <= S_JAL_JUMP;
        S_JAL_JUMP:   r_state <= S_LINK;
        S_JALR:       r_state <= S_LINK;
        S_TRAP:       r_state <= S_TRAP;
        default:      r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; reset forces every output low so an aborted access never commits
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    result_src    = RES_ALUOUT;
    imm_src       = IMM_I;
    illegal_instr = 1'b0;
    w_alu_op      = ALUOP_ADD;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_RESULT;
          ir_write   = w_ready;
          pc_write   = w_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_B;
        end
        S_MEM_ADR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          imm_src   = opcode[5] ? IMM_S : IMM_I;
        end
        S_MEM_READ: begin
          adr_src  = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEM_WRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_REG;
          w_alu_op  = ALUOP_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          w_alu_op  = ALUOP_FUNCT;
        end
        S_EXEC_LUI: begin
          alu_src_a = SRC_A_ZERO;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_U;
        end
        S_EXEC_AUIPC: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_U;
        end
        S_ALU_WB:   reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRC_A_REG;
          w_alu_op  = ALUOP_BRANCH;
          pc_write  = w_taken && w_branch_ok;
        end
        S_JAL: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_J;
        end
        S_JAL_JUMP: pc_write = 1'b1;
        S_JALR: begin
          alu_src_a  = SRC_A_REG;
          alu_src_b  = SRC_B_IMM;
          result_src = RES_ALU_RESULT;
          pc_write   = 1'b1;
        end
        S_LINK: begin
          alu_src_a  = SRC_A_OLDPC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_RESULT;
          reg_write  = 1'b1;
        end
        S_TRAP:     illegal_instr = 1'b1;
        default:    illegal_instr = 1'b0;
      endcase
    end
  end

  multicycle_control_alu_decoder u_alu_decoder (
    .alu_op      (w_alu_op),
    .op_bit5     (opcode[5]),
    .funct3      (funct3),
    .funct7_bit5 (funct7[5]),
    .alu_control (alu_control)
  );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ------------------------------------------------------------------
// tb_multicycle_control: scoreboard bench for the multicycle control FSM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;
  import multicycle_control_pkg::ALU_ADD;
  import multicycle_control_pkg::ALU_SUB;
  import multicycle_control_pkg::ALU_SLT;
  import multicycle_control_pkg::ALU_SLTU;
  import multicycle_control_pkg::ALU_SRA;
  import multicycle_control_pkg::ALU_OR;

  localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_REG = 2'd2, A_ZERO = 2'd3;
  localparam logic [1:0] B_REG = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
  localparam logic [1:0] R_OUT = 2'd0, R_DATA = 2'd1, R_RES = 2'd2;
  localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2, I_U = 3'd3, I_J = 3'd4;

  typedef struct packed {
    logic       pcw, adr, mrd, mwr, irw, rgw;
    logic [1:0] a, b, res;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1, rst_nt = 1'b1;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b1;

  logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic nt_pcw, nt_adr, nt_mrd, nt_mwr, nt_irw, nt_rgw, nt_ill;
  logic [1:0] nt_a, nt_b, nt_res;
  logic [2:0] nt_imm;
  logic [3:0] nt_alu;

  vec_t w_main, w_nt;
  vec_t exp_q[$];
  int   n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
  );

  multicycle_control #(.MEM_WAIT(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .rst(rst_nt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_write(nt_pcw), .adr_src(nt_adr),
    .mem_read(nt_mrd), .mem_write(nt_mwr), .ir_write(nt_irw), .reg_write(nt_rgw),
    .alu_src_a(nt_a), .alu_src_b(nt_b), .result_src(nt_res),
    .imm_src(nt_imm), .alu_control(nt_alu), .illegal_instr(nt_ill)
  );

  assign w_main = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                   alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal_instr};
  assign w_nt   = {nt_pcw, nt_adr, nt_mrd, nt_mwr, nt_irw, nt_rgw,
                   nt_a, nt_b, nt_res, nt_imm, nt_alu, nt_ill};

  function automatic vec_t v(input logic pcw, adr, mrd, mwr, irw, rgw,
                             input logic [1:0] a, b, res, input logic [2:0] imm,
                             input logic [3:0] alu, input logic ill);
    return '{pcw, adr, mrd, mwr, irw, rgw, a, b, res, imm, alu, ill};
  endfunction

  function automatic vec_t e_fetch(input logic r);
    return v(r, 0, 1, 0, r, 0, A_PC, B_FOUR, R_RES, I_I, ALU_ADD, 0);
  endfunction

  function automatic vec_t e_decode();
    return v(0, 0, 0, 0, 0, 0, A_OLD, B_IMM, R_OUT, I_B, ALU_ADD, 0);
  endfunction

  function automatic vec_t e_alu_wb();
    return v(0, 0, 0, 0, 0, 1, A_PC, B_REG, R_OUT, I_I, ALU_ADD, 0);
  endfunction

  function automatic vec_t e_link();
    return v(0, 0, 0, 0, 0, 1, A_OLD, B_FOUR, R_RES, I_I, ALU_ADD, 0);
  endfunction

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock of stimulus: drive, queue the expectation, compare at negedge
  task automatic cyc(input string tag, input logic rdy, input logic zero,
                     input logic rs, input vec_t e, input bit sel);
    vec_t want;
    if (sel) rst_nt = rs; else rst = rs;
    mem_ready = rdy;
    alu_zero  = zero;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    check(tag, sel ? w_nt : w_main, want);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  logic [6:0] alu_opc [5] = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h33};
  logic [2:0] alu_f3  [5] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd6};
  logic [6:0] alu_f7  [5] = '{7'h00, 7'h20, 7'h20, 7'h20, 7'h00};
  logic [3:0] alu_exp [5] = '{ALU_ADD, ALU_SUB, ALU_SRA, ALU_ADD, ALU_OR};

  logic [2:0] br_f3   [6] = '{3'b001, 3'b001, 3'b000, 3'b111, 3'b111, 3'b100};
  logic       br_zero [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0] br_alu  [6] = '{ALU_SUB, ALU_SUB, ALU_SUB, ALU_SLTU, ALU_SLTU, ALU_SLT};
  logic       br_tk   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    cyc("reset0", 1, 0, 1, '0, 0);
    cyc("reset1", 0, 0, 1, '0, 0);

    // R-type and I-type ALU decode, including ADDI with funct7[5] set
    for (int i = 0; i < 5; i++) begin
      instr(alu_opc[i], alu_f3[i], alu_f7[i]);
      cyc("alu_fetch", 1, 0, 0, e_fetch(1), 0);
      cyc("alu_decode", 1, 0, 0, e_decode(), 0);
      cyc("alu_exec", 1, 0, 0,
          v(0, 0, 0, 0, 0, 0, A_REG, alu_opc[i][5] ? B_REG : B_IMM, R_OUT, I_I, alu_exp[i], 0), 0);
      cyc("alu_wb", 1, 0, 0, e_alu_wb(), 0);
    end

    // LW with 2 fetch waits and 3 read waits: 10 cycles
    instr(7'h03, 3'd2, 7'h00);
    cyc("lw_fetch_wait", 0, 0, 0, e_fetch(0), 0);
    cyc("lw_fetch_wait", 0, 0, 0, e_fetch(0), 0);
    cyc("lw_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("lw_decode", 1, 0, 0, e_decode(), 0);
    cyc("lw_adr", 1, 0, 0, v(0, 0, 0, 0, 0, 0, A_REG, B_IMM, R_OUT, I_I, ALU_ADD, 0), 0);
    for (int i = 0; i < 4; i++)
      cyc("lw_read", (i == 3), 0, 0, v(0, 1, 1, 0, 0, 0, A_PC, B_REG, R_OUT, I_I, ALU_ADD, 0), 0);
    cyc("lw_wb", 1, 0, 0, v(0, 0, 0, 0, 0, 1, A_PC, B_REG, R_DATA, I_I, ALU_ADD, 0), 0);

    // SW with 2 write waits, mem_write held through the wait
    instr(7'h23, 3'd2, 7'h00);
    cyc("sw_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("sw_decode", 1, 0, 0, e_decode(), 0);
    cyc("sw_adr", 1, 0, 0, v(0, 0, 0, 0, 0, 0, A_REG, B_IMM, R_OUT, I_S, ALU_ADD, 0), 0);
    for (int i = 0; i < 3; i++)
      cyc("sw_write", (i == 2), 0, 0, v(0, 1, 0, 1, 0, 0, A_PC, B_REG, R_OUT, I_I, ALU_ADD, 0), 0);

    // branches: operation and taken per funct3/alu_zero
    for (int i = 0; i < 6; i++) begin
      instr(7'h63, br_f3[i], 7'h00);
      cyc("br_fetch", 1, 0, 0, e_fetch(1), 0);
      cyc("br_decode", 1, 0, 0, e_decode(), 0);
      cyc("br_exec", 1, br_zero[i], 0,
          v(br_tk[i], 0, 0, 0, 0, 0, A_REG, B_REG, R_OUT, I_I, br_alu[i], 0), 0);
    end

    instr(7'h6F, 3'd0, 7'h00);
    cyc("jal_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("jal_decode", 1, 0, 0, e_decode(), 0);
    cyc("jal_target", 1, 0, 0, v(0, 0, 0, 0, 0, 0, A_OLD, B_IMM, R_OUT, I_J, ALU_ADD, 0), 0);
    cyc("jal_jump", 1, 0, 0, v(1, 0, 0, 0, 0, 0, A_PC, B_REG, R_OUT, I_I, ALU_ADD, 0), 0);
    cyc("jal_link", 1, 0, 0, e_link(), 0);

    instr(7'h67, 3'd0, 7'h00);
    cyc("jalr_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("jalr_decode", 1, 0, 0, e_decode(), 0);
    cyc("jalr_jump", 1, 0, 0, v(1, 0, 0, 0, 0, 0, A_REG, B_IMM, R_RES, I_I, ALU_ADD, 0), 0);
    cyc("jalr_link", 1, 0, 0, e_link(), 0);

    instr(7'h37, 3'd0, 7'h00);
    cyc("lui_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("lui_decode", 1, 0, 0, e_decode(), 0);
    cyc("lui_exec", 1, 0, 0, v(0, 0, 0, 0, 0, 0, A_ZERO, B_IMM, R_OUT, I_U, ALU_ADD, 0), 0);
    cyc("lui_wb", 1, 0, 0, e_alu_wb(), 0);

    instr(7'h17, 3'd0, 7'h00);
    cyc("auipc_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("auipc_decode", 1, 0, 0, e_decode(), 0);
    cyc("auipc_exec", 1, 0, 0, v(0, 0, 0, 0, 0, 0, A_OLD, B_IMM, R_OUT, I_U, ALU_ADD, 0), 0);
    cyc("auipc_wb", 1, 0, 0, e_alu_wb(), 0);

    // reset during a stalled store aborts it
    instr(7'h23, 3'd2, 7'h00);
    cyc("swr_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("swr_decode", 1, 0, 0, e_decode(), 0);
    cyc("swr_adr", 1, 0, 0, v(0, 0, 0, 0, 0, 0, A_REG, B_IMM, R_OUT, I_S, ALU_ADD, 0), 0);
    cyc("swr_write", 0, 0, 0, v(0, 1, 0, 1, 0, 0, A_PC, B_REG, R_OUT, I_I, ALU_ADD, 0), 0);
    cyc("swr_rst", 0, 0, 1, '0, 0);
    cyc("swr_refetch", 0, 0, 0, e_fetch(0), 0);

    // illegal opcode: sticky trap until reset
    instr(7'h7F, 3'd0, 7'h00);
    cyc("ill_fetch", 1, 0, 0, e_fetch(1), 0);
    cyc("ill_decode", 1, 0, 0, e_decode(), 0);
    for (int i = 0; i < 20; i++)
      cyc("ill_trap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
          v(0, 0, 0, 0, 0, 0, A_PC, B_REG, R_OUT, I_I, ALU_ADD, 1), 0);
    cyc("ill_rst", 1, 0, 1, '0, 0);
    cyc("ill_refetch", 0, 0, 0, e_fetch(0), 0);

    // no-trap, no-wait variant: illegal opcode is a NOP, mem_ready ignored
    cyc("nt_rst", 0, 0, 1, '0, 1);
    cyc("nt_fetch", 0, 0, 0, e_fetch(1), 1);
    cyc("nt_decode", 0, 0, 0, e_decode(), 1);
    cyc("nt_refetch", 0, 0, 0, e_fetch(1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
